// File: rtl/egress_wrr_scheduler.sv
// Weighted round-robin egress arbiter: one-hot grant to a requesting input port,
// per-port credits reloaded from cfg_weight, forced release after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no grant; arbitrate as soon as any req is high
// BUSY  | grant held until done, abort (granted req drops) or hold timeout
// GAP   | single dead cycle between grants
module egress_wrr_scheduler #(
  parameter int NREQ     = 4,
  parameter int CW       = 3,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic               done,
  input  logic [NREQ*CW-1:0] cfg_weight,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NREQ-1:0]          grant_q, grant_d;
  logic [PW-1:0]            gidx_q, gidx_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic [NREQ-1:0][CW-1:0]  credit_q, credit_d;
  logic                     tmo_q, tmo_d;

  logic [NREQ-1:0][CW-1:0]  weight_eff;
  logic [NREQ-1:0]          has_credit, elig;
  logic                     reload, pick_vld;
  logic [PW-1:0]            pick_idx, scan_idx;
  logic                     gnt_req, end_abort, end_tmo;
  logic [CW-1:0]            credit_left;

  // When no requester has credit, the scan runs on the freshly reloaded weights,
  // all of which are non-zero, so every requester becomes eligible.
  always_comb begin
    weight_eff = '0;
    has_credit = '0;
    pick_vld   = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      weight_eff[i] = (cfg_weight[i*CW +: CW] == '0) ? CW'(1) : cfg_weight[i*CW +: CW];
      has_credit[i] = req[i] && (credit_q[i] != '0);
    end
    reload = (|req) && !(|has_credit);
    elig   = reload ? req : has_credit;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = rr_ptr_q + PW'(i);
      if (!pick_vld && elig[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign gnt_req   = req[gidx_q];
  assign end_abort = !done && !gnt_req;
  assign end_tmo   = !done && gnt_req && (hold_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_BUSY;
      ST_BUSY: if (done || end_abort || end_tmo) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    credit_d    = credit_q;
    tmo_d       = 1'b0;
    credit_left = '0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_vld) begin
          if (reload) credit_d = weight_eff;
          grant_d = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          hold_d  = '0;
        end
      end
      ST_BUSY: begin
        if (hold_q != HOLD_SAT) hold_d = hold_q + HW'(1);
        if (done) begin
          credit_left        = (credit_q[gidx_q] == '0) ? '0 : credit_q[gidx_q] - CW'(1);
          credit_d[gidx_q]   = credit_left;
          grant_d            = '0;
          rr_ptr_d           = (credit_left != '0) ? gidx_q : gidx_q + PW'(1);
        end else if (end_abort) begin
          grant_d  = '0;
          rr_ptr_d = gidx_q + PW'(1);
        end else if (end_tmo) begin
          grant_d          = '0;
          credit_d[gidx_q] = '0;
          rr_ptr_d         = gidx_q + PW'(1);
          tmo_d            = 1'b1;
        end
      end
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      credit_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = |grant_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_egress_wrr_scheduler.sv
// Directed bench for egress_wrr_scheduler: vector table for arbitration order,
// hand-written sequences for timeout, done/timeout collision and async reset.
module tb_egress_wrr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic        done;
  logic [11:0] cfg_weight;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  egress_wrr_scheduler #(.NREQ(4), .CW(3), .MAX_HOLD(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .cfg_weight  (cfg_weight),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        done;
    logic [11:0] cfg;
    logic [3:0]  eg;
    logic        et;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [3:0] r, input logic d,
                         input logic [11:0] c, input logic [3:0] eg, input logic et);
    vec_t v;
    v.rst = rst; v.req = r; v.done = d; v.cfg = c; v.eg = eg; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int idx, input logic [3:0] eg, input logic et);
    check({name, "_grant"}, idx, 32'(grant), 32'(eg));
    check({name, "_busy"}, idx, 32'(busy), 32'(|eg));
    check({name, "_tmo"}, idx, 32'(timeout_err), 32'(et));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [11:0] W_ALL1  = 12'h249; // 1,1,1,1
  localparam logic [11:0] W_P0_3  = 12'h24B; // port0=3, others 1
  localparam logic [11:0] W_P1_0  = 12'h241; // port1=0 (acts as 1)
  localparam logic [11:0] W_P2_2  = 12'h289; // port2=2, others 1

  int held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    done = 1'b0;
    cfg_weight = W_ALL1;
    #3;
    check_outs("reset_state", 0, 4'b0000, 1'b0);

    // single port, extra req bits mid-BUSY ignored, done in IDLE ignored, then rotation
    add_vec(1, 4'b0001, 0, W_ALL1, 4'b0001, 0);
    add_vec(0, 4'b1011, 0, W_ALL1, 4'b0001, 0);
    add_vec(0, 4'b0001, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b0000, 0, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b0000, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_ALL1, 4'b0010, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_ALL1, 4'b0100, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_ALL1, 4'b1000, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_ALL1, 4'b0001, 0);
    add_vec(0, 4'b1111, 1, W_ALL1, 4'b0000, 0);
    // port0 weight 3: three consecutive grants before moving on
    add_vec(1, 4'b1111, 0, W_P0_3, 4'b0001, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0001, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0001, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0010, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0100, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b1000, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0000, 0);
    add_vec(0, 4'b1111, 0, W_P0_3, 4'b0001, 0);
    add_vec(0, 4'b1111, 1, W_P0_3, 4'b0000, 0);
    // weight 0 behaves as 1
    add_vec(1, 4'b0010, 0, W_P1_0, 4'b0010, 0);
    add_vec(0, 4'b0010, 1, W_P1_0, 4'b0000, 0);
    add_vec(0, 4'b0010, 0, W_P1_0, 4'b0000, 0);
    add_vec(0, 4'b0010, 0, W_P1_0, 4'b0010, 0);
    add_vec(0, 4'b0010, 1, W_P1_0, 4'b0000, 0);
    // abort leaves credit intact: port2 keeps 2 credits, so it wins again after a done
    add_vec(1, 4'b0100, 0, W_P2_2, 4'b0100, 0);
    add_vec(0, 4'b0000, 0, W_P2_2, 4'b0000, 0);
    add_vec(0, 4'b0000, 0, W_P2_2, 4'b0000, 0);
    add_vec(0, 4'b0100, 0, W_P2_2, 4'b0100, 0);
    add_vec(0, 4'b0100, 1, W_P2_2, 4'b0000, 0);
    add_vec(0, 4'b1100, 0, W_P2_2, 4'b0000, 0);
    add_vec(0, 4'b1100, 0, W_P2_2, 4'b0100, 0);
    add_vec(0, 4'b1100, 1, W_P2_2, 4'b0000, 0);
    add_vec(0, 4'b1100, 0, W_P2_2, 4'b0000, 0);
    add_vec(0, 4'b1100, 0, W_P2_2, 4'b1000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      req        = vecs[i].req;
      done       = vecs[i].done;
      cfg_weight = vecs[i].cfg;
      @(posedge clk);
      #1;
      check_outs("vec", i, vecs[i].eg, vecs[i].et);
    end

    // hold timeout on port2, then port3 wins
    do_reset();
    @(negedge clk);
    cfg_weight = W_ALL1;
    req = 4'b0100;
    done = 1'b0;
    @(posedge clk);
    #1;
    check_outs("tmo_start", 0, 4'b0100, 1'b0);
    held = 1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (grant == 4'b0100 && timeout_err == 1'b0) held++;
      else break;
    end
    check("tmo_hold_len", 0, 32'(held), 32'd64);
    check_outs("tmo_release", 0, 4'b0000, 1'b1);
    @(negedge clk);
    req = 4'b1100;
    @(posedge clk);
    #1;
    check_outs("tmo_pulse_end", 0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_outs("tmo_next_grant", 0, 4'b1000, 1'b0);

    // done on the timeout boundary cycle: done wins
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    @(posedge clk);
    #1;
    repeat (63) @(posedge clk);
    #1;
    check_outs("bound_held", 0, 4'b0100, 1'b0);
    @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #1;
    check_outs("bound_done", 0, 4'b0000, 1'b0);
    @(negedge clk);
    done = 1'b0;
    @(posedge clk);
    #1;
    check_outs("bound_after", 0, 4'b0000, 1'b0);

    // asynchronous reset mid-BUSY
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    @(posedge clk);
    #1;
    check_outs("arst_busy", 0, 4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("arst_drop", 0, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    #1;
    check_outs("arst_quiet", 0, 4'b0000, 1'b0);
    @(negedge clk);
    req = 4'b0100;
    @(posedge clk);
    #1;
    check_outs("arst_regrant", 0, 4'b0100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
